// File: rtl/hdmi_packet_pkg.sv
// Shared types and helpers for the HDMI data-island packet scheduler:
// packet source select encoding, HB0 header bytes and the slot priority order.
package hdmi_packet_pkg;

  typedef enum logic [2:0] {
    SEL_NULL     = 3'd0,
    SEL_ACR      = 3'd1,
    SEL_AUDIO    = 3'd2,
    SEL_AVI      = 3'd3,
    SEL_AUDIO_IF = 3'd4,
    SEL_SPD      = 3'd5
  } packet_sel_t;

  localparam logic [7:0] HB0_NULL     = 8'h00;
  localparam logic [7:0] HB0_ACR      = 8'h01;
  localparam logic [7:0] HB0_AUDIO    = 8'h02;
  localparam logic [7:0] HB0_AVI      = 8'h82;
  localparam logic [7:0] HB0_AUDIO_IF = 8'h84;
  localparam logic [7:0] HB0_SPD      = 8'h83;

  localparam int PACKET_CYCLES = 32;

  // Bit positions inside the pending-request vector handed to select_packet.
  localparam int PEND_ACR      = 0;
  localparam int PEND_AUDIO    = 1;
  localparam int PEND_AVI      = 2;
  localparam int PEND_AUDIO_IF = 3;
  localparam int PEND_SPD      = 4;

  // Fixed priority: ACR > AUDIO > AVI > AUDIO_IF > SPD > NULL.
  function automatic packet_sel_t select_packet(input logic [4:0] pend);
    packet_sel_t sel;
    if (pend[PEND_ACR]) begin
      sel = SEL_ACR;
    end else if (pend[PEND_AUDIO]) begin
      sel = SEL_AUDIO;
    end else if (pend[PEND_AVI]) begin
      sel = SEL_AVI;
    end else if (pend[PEND_AUDIO_IF]) begin
      sel = SEL_AUDIO_IF;
    end else if (pend[PEND_SPD]) begin
      sel = SEL_SPD;
    end else begin
      sel = SEL_NULL;
    end
    return sel;
  endfunction

  // HB0 (packet type byte) that goes with each source select.
  function automatic logic [7:0] packet_hb0(input packet_sel_t sel);
    logic [7:0] hb0;
    case (sel)
      SEL_ACR:      hb0 = HB0_ACR;
      SEL_AUDIO:    hb0 = HB0_AUDIO;
      SEL_AVI:      hb0 = HB0_AVI;
      SEL_AUDIO_IF: hb0 = HB0_AUDIO_IF;
      SEL_SPD:      hb0 = HB0_SPD;
      default:      hb0 = HB0_NULL;
    endcase
    return hb0;
  endfunction

endpackage

// File: rtl/hdmi_packet_scheduler_if.sv
// Bundle between the timing generator / audio / ACR sources (master side)
// and the packet scheduler (slave side), which drives the assembler controls.
interface hdmi_packet_scheduler_if;
  import hdmi_packet_pkg::*;

  logic        island_start;
  logic [4:0]  island_packets;
  logic        frame_start;
  logic        acr_wrap;
  logic        audio_pending;
  logic        audio_pop;
  logic        island_active;
  logic        packet_start;
  logic [4:0]  packet_pixel;
  packet_sel_t packet_sel;
  logic [7:0]  packet_type;
  logic        island_overlap;

  modport master (
    output island_start, island_packets, frame_start, acr_wrap, audio_pending,
    input  audio_pop, island_active, packet_start, packet_pixel, packet_sel,
           packet_type, island_overlap
  );

  modport slave (
    input  island_start, island_packets, frame_start, acr_wrap, audio_pending,
    output audio_pop, island_active, packet_start, packet_pixel, packet_sel,
           packet_type, island_overlap
  );

endinterface

// File: rtl/hdmi_packet_scheduler.sv
// Picks the packet carried in each 32-pixel slot of a data island and drives
// the assembler's source select, HB0 and in-slot pixel index. All outputs
// come straight from registers.
module hdmi_packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int MAX_PACKETS      = 18,
  parameter int INFOFRAME_PERIOD = 1,
  parameter bit SPD_ENABLE       = 1'b1
) (
  input logic clk_pixel,
  input logic reset,
  hdmi_packet_scheduler_if.slave bus
);

  localparam logic [4:0] MAX_SLOTS  = 5'(MAX_PACKETS);
  localparam logic [4:0] PIX_LAST   = 5'(PACKET_CYCLES - 1);
  localparam logic [7:0] FRAME_LAST = 8'(INFOFRAME_PERIOD - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state;
  logic [4:0]  pix;
  logic [4:0]  slots_left;
  logic [7:0]  frame_cnt;
  logic        acr_wrap_q;
  logic        acr_pend;
  logic        avi_pend;
  logic        aif_pend;
  logic        spd_pend;
  logic        active;
  logic        start_pulse;
  logic        pop;
  logic        overlap;
  packet_sel_t cur_sel;
  logic [7:0]  cur_type;

  logic [4:0]  slot_count;
  logic        decide;
  logic        acr_set;
  logic        info_set;
  packet_sel_t choice;

  // Clamp the requested slot count into 1..MAX_PACKETS.
  always_comb begin
    slot_count = bus.island_packets;
    if (bus.island_packets == 5'd0) begin
      slot_count = 5'd1;
    end else if (bus.island_packets > MAX_SLOTS) begin
      slot_count = MAX_SLOTS;
    end else begin
      slot_count = bus.island_packets;
    end
  end

  // Slot-decision strobe, new-request detection and the priority pick.
  always_comb begin
    decide   = ((state == IDLE) && bus.island_start) ||
               ((state == ACTIVE) && (pix == PIX_LAST) && (slots_left != 5'd1));
    acr_set  = (bus.acr_wrap != acr_wrap_q);
    info_set = bus.frame_start && (frame_cnt == 8'd0);
    choice   = select_packet({spd_pend, aif_pend, avi_pend, bus.audio_pending, acr_pend});
  end

  // Island FSM, slot timer, pending flags and registered outputs.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state       <= IDLE;
      pix         <= 5'd0;
      slots_left  <= 5'd0;
      frame_cnt   <= 8'd0;
      acr_wrap_q  <= bus.acr_wrap;
      acr_pend    <= 1'b0;
      avi_pend    <= 1'b0;
      aif_pend    <= 1'b0;
      spd_pend    <= 1'b0;
      active      <= 1'b0;
      start_pulse <= 1'b0;
      pop         <= 1'b0;
      overlap     <= 1'b0;
      cur_sel     <= SEL_NULL;
      cur_type    <= HB0_NULL;
    end else begin
      // A new request in the consuming cycle wins over the clear.
      acr_wrap_q <= bus.acr_wrap;
      acr_pend   <= acr_set | (acr_pend & ~(decide && (choice == SEL_ACR)));
      avi_pend   <= info_set | (avi_pend & ~(decide && (choice == SEL_AVI)));
      aif_pend   <= info_set | (aif_pend & ~(decide && (choice == SEL_AUDIO_IF)));
      spd_pend   <= (info_set & SPD_ENABLE) | (spd_pend & ~(decide && (choice == SEL_SPD)));

      if (bus.frame_start) begin
        frame_cnt <= (frame_cnt == FRAME_LAST) ? 8'd0 : frame_cnt + 8'd1;
      end

      start_pulse <= decide;
      pop         <= decide && (choice == SEL_AUDIO);
      if (decide) begin
        cur_sel  <= choice;
        cur_type <= packet_hb0(choice);
      end

      case (state)
        IDLE: begin
          if (bus.island_start) begin
            state      <= ACTIVE;
            active     <= 1'b1;
            pix        <= 5'd0;
            slots_left <= slot_count;
          end
        end
        ACTIVE: begin
          if (bus.island_start) begin
            overlap <= 1'b1;
          end
          if (pix == PIX_LAST) begin
            pix <= 5'd0;
            if (slots_left == 5'd1) begin
              state    <= IDLE;
              active   <= 1'b0;
              cur_sel  <= SEL_NULL;
              cur_type <= HB0_NULL;
            end else begin
              slots_left <= slots_left - 5'd1;
            end
          end else begin
            pix <= pix + 5'd1;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.island_active  = active;
  assign bus.packet_start   = start_pulse;
  assign bus.packet_pixel   = pix;
  assign bus.packet_sel     = cur_sel;
  assign bus.packet_type    = cur_type;
  assign bus.audio_pop      = pop;
  assign bus.island_overlap = overlap;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed bench for hdmi_packet_scheduler: a slot-count vector table plus
// hand sequences for priority, InfoFrame period, ACR races, overlap and reset.
module tb_hdmi_packet_scheduler;
  import hdmi_packet_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hdmi_packet_scheduler_if ia();
  hdmi_packet_scheduler_if ib();

  hdmi_packet_scheduler #(.MAX_PACKETS(18), .INFOFRAME_PERIOD(1), .SPD_ENABLE(1'b1)) dut_a (
    .clk_pixel(clk), .reset(reset), .bus(ia.slave));

  hdmi_packet_scheduler #(.MAX_PACKETS(18), .INFOFRAME_PERIOD(2), .SPD_ENABLE(1'b0)) dut_b (
    .clk_pixel(clk), .reset(reset), .bus(ib.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor mux: which DUT the island runner observes and drives.
  bit          use_b;
  logic        m_active, m_start, m_pop;
  logic [4:0]  m_pix;
  logic [2:0]  m_sel;
  logic [7:0]  m_type;
  always_comb begin
    if (use_b) begin
      m_active = ib.island_active; m_start = ib.packet_start; m_pop = ib.audio_pop;
      m_pix = ib.packet_pixel; m_sel = ib.packet_sel; m_type = ib.packet_type;
    end else begin
      m_active = ia.island_active; m_start = ia.packet_start; m_pop = ia.audio_pop;
      m_pix = ia.packet_pixel; m_sel = ia.packet_sel; m_type = ia.packet_type;
    end
  end

  // Results of the most recent island.
  logic [2:0] got_sel  [32];
  logic [7:0] got_type [32];
  int n_slots, n_cycles, n_pops, pop_slot, seq_ok, audio_count;

  typedef struct { logic [4:0] ip; int exp_slots; } slot_vec_t;
  slot_vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_start(input logic v, input logic [4:0] ip);
    if (use_b) begin
      ib.island_start = v; ib.island_packets = ip;
    end else begin
      ia.island_start = v; ia.island_packets = ip;
    end
  endtask

  // Start an island, follow it to its end and record per-slot selections.
  task automatic run_island(input logic [4:0] ip, input bit tog_acr, input int overlap_at);
    int cyc;
    drive_start(1'b1, ip);
    if (tog_acr) ia.acr_wrap = ~ia.acr_wrap;
    tick();
    drive_start(1'b0, ip);
    n_slots = 0; n_pops = 0; pop_slot = -1; seq_ok = 1; cyc = 0;
    while (m_active && cyc < 1000) begin
      if (m_start != ((cyc % 32) == 0)) seq_ok = 0;
      if (m_pix != 5'(cyc % 32)) seq_ok = 0;
      if (m_start) begin
        if (n_slots < 32) begin
          got_sel[n_slots] = m_sel; got_type[n_slots] = m_type;
        end
        n_slots++;
      end else if (n_slots > 0 && n_slots <= 32) begin
        if (m_sel != got_sel[n_slots-1] || m_type != got_type[n_slots-1]) seq_ok = 0;
      end
      if (m_pop) begin
        n_pops++; pop_slot = n_slots - 1;
        if (!m_start) seq_ok = 0;
        if (audio_count > 0) audio_count--;
        ia.audio_pending = (audio_count > 0);
      end
      tick();
      cyc++;
      drive_start(cyc == overlap_at, ip);
    end
    drive_start(1'b0, ip);
    n_cycles = cyc;
    if (cyc >= 1000) check("island_timeout", cyc, 0);
  endtask

  task automatic check_idle(input string name);
    check({name, "_active"}, int'(m_active), 0);
    check({name, "_sel"}, int'(m_sel), int'(SEL_NULL));
    check({name, "_type"}, int'(m_type), 0);
  endtask

  packet_sel_t exp2_sel  [6];
  logic [7:0]  exp2_type [6];

  initial begin
    checks = 0; errors = 0; use_b = 1'b0; audio_count = 0;
    reset = 1'b1;
    ia.island_start = 1'b0; ia.island_packets = 5'd0; ia.frame_start = 1'b0;
    ia.acr_wrap = 1'b0; ia.audio_pending = 1'b0;
    ib.island_start = 1'b0; ib.island_packets = 5'd0; ib.frame_start = 1'b0;
    ib.acr_wrap = 1'b0; ib.audio_pending = 1'b0;

    vecs[0] = '{5'd3, 3};
    vecs[1] = '{5'd0, 1};
    vecs[2] = '{5'd1, 1};
    vecs[3] = '{5'd18, 18};
    vecs[4] = '{5'd19, 18};
    vecs[5] = '{5'd31, 18};

    repeat (3) tick();
    // Reset state
    check("rst_a_active", int'(ia.island_active), 0);
    check("rst_a_start", int'(ia.packet_start), 0);
    check("rst_a_pixel", int'(ia.packet_pixel), 0);
    check("rst_a_sel", int'(ia.packet_sel), int'(SEL_NULL));
    check("rst_a_type", int'(ia.packet_type), 0);
    check("rst_a_pop", int'(ia.audio_pop), 0);
    check("rst_a_overlap", int'(ia.island_overlap), 0);
    check("rst_b_active", int'(ib.island_active), 0);
    check("rst_b_sel", int'(ib.packet_sel), int'(SEL_NULL));
    reset = 1'b0;
    tick();

    // Slot-count table: no requests, every slot NULL, 32 cycles per slot
    for (int i = 0; i < 6; i++) begin
      int nonnull;
      run_island(vecs[i].ip, 1'b0, -1);
      check($sformatf("tbl%0d_slots", i), n_slots, vecs[i].exp_slots);
      check($sformatf("tbl%0d_cycles", i), n_cycles, 32 * vecs[i].exp_slots);
      check($sformatf("tbl%0d_seq", i), seq_ok, 1);
      check($sformatf("tbl%0d_pops", i), n_pops, 0);
      nonnull = 0;
      for (int s = 0; s < n_slots && s < 32; s++)
        if (got_sel[s] != SEL_NULL || got_type[s] != 8'h00) nonnull++;
      check($sformatf("tbl%0d_nonnull", i), nonnull, 0);
      check_idle($sformatf("tbl%0d_idle", i));
      tick();
    end

    // Full priority order in one six-slot island
    ia.acr_wrap = ~ia.acr_wrap;
    audio_count = 1; ia.audio_pending = 1'b1;
    tick();
    ia.frame_start = 1'b1;
    tick();
    ia.frame_start = 1'b0;
    run_island(5'd6, 1'b0, -1);
    exp2_sel[0] = SEL_ACR;      exp2_type[0] = 8'h01;
    exp2_sel[1] = SEL_AUDIO;    exp2_type[1] = 8'h02;
    exp2_sel[2] = SEL_AVI;      exp2_type[2] = 8'h82;
    exp2_sel[3] = SEL_AUDIO_IF; exp2_type[3] = 8'h84;
    exp2_sel[4] = SEL_SPD;      exp2_type[4] = 8'h83;
    exp2_sel[5] = SEL_NULL;     exp2_type[5] = 8'h00;
    check("t2_slots", n_slots, 6);
    check("t2_seq", seq_ok, 1);
    for (int s = 0; s < 6; s++) begin
      check($sformatf("t2_sel%0d", s), int'(got_sel[s]), int'(exp2_sel[s]));
      check($sformatf("t2_type%0d", s), int'(got_type[s]), int'(exp2_type[s]));
    end
    check("t2_pops", n_pops, 1);
    check("t2_pop_slot", pop_slot, 1);
    check_idle("t2_idle");
    tick();

    // ACR edge in the very cycle the ACR slot is decided stays pending
    ia.acr_wrap = ~ia.acr_wrap;
    tick();
    run_island(5'd1, 1'b1, -1);
    check("t4_first", int'(got_sel[0]), int'(SEL_ACR));
    run_island(5'd1, 1'b0, -1);
    check("t4_second", int'(got_sel[0]), int'(SEL_ACR));
    check("t4_second_type", int'(got_type[0]), 8'h01);
    run_island(5'd1, 1'b0, -1);
    check("t4_third", int'(got_sel[0]), int'(SEL_NULL));

    // island_start mid-island: ignored, sticky overlap flag
    check("t5_ovl_before", int'(ia.island_overlap), 0);
    run_island(5'd2, 1'b0, 40);
    check("t5_ovl_slots", n_slots, 2);
    check("t5_ovl_cycles", n_cycles, 64);
    check("t5_ovl_set", int'(ia.island_overlap), 1);
    run_island(5'd1, 1'b0, -1);
    check("t5_ovl_sticky", int'(ia.island_overlap), 1);

    // Second instance: SPD disabled, InfoFrames every other frame
    use_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ib.frame_start = 1'b1;
      tick();
      ib.frame_start = 1'b0;
      run_island(5'd3, 1'b0, -1);
      check($sformatf("t3_f%0d_slots", k), n_slots, 3);
      check($sformatf("t3_f%0d_s0", k), int'(got_sel[0]), (k % 2 == 0) ? int'(SEL_AVI) : int'(SEL_NULL));
      check($sformatf("t3_f%0d_s1", k), int'(got_sel[1]), (k % 2 == 0) ? int'(SEL_AUDIO_IF) : int'(SEL_NULL));
      check($sformatf("t3_f%0d_s2", k), int'(got_sel[2]), int'(SEL_NULL));
      check($sformatf("t3_f%0d_t1", k), int'(got_type[1]), (k % 2 == 0) ? 8'h84 : 8'h00);
    end
    use_b = 1'b0;

    // Reset in the middle of slot index 1 with flags pending
    ia.acr_wrap = 1'b0;
    ia.frame_start = 1'b1;
    tick();
    ia.frame_start = 1'b0;
    ia.island_start = 1'b1; ia.island_packets = 5'd4;
    tick();
    ia.island_start = 1'b0;
    repeat (42) tick();
    check("t6_pix_pre", int'(ia.packet_pixel), 10);
    check("t6_sel_pre", int'(ia.packet_sel), int'(SEL_AVI));
    reset = 1'b1; ia.acr_wrap = 1'b1;
    tick();
    check("t6_active", int'(ia.island_active), 0);
    check("t6_pixel", int'(ia.packet_pixel), 0);
    check("t6_sel", int'(ia.packet_sel), int'(SEL_NULL));
    check("t6_type", int'(ia.packet_type), 0);
    check("t6_start", int'(ia.packet_start), 0);
    check("t6_overlap", int'(ia.island_overlap), 0);
    reset = 1'b0;
    tick();
    run_island(5'd1, 1'b0, -1);
    check("t6_after_slots", n_slots, 1);
    check("t6_after_sel", int'(got_sel[0]), int'(SEL_NULL));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
